// File: rtl/prim_query_arbiter_pkg.sv
// rtl/prim_query_arbiter_pkg.sv - shared types and defaults for the primitive query arbiter
//
// Holds the requester ID enum, the range-query struct built on the primitive and
// node index types, the lock FSM state enum, and a width helper. The struct uses
// the default index widths.
package prim_query_arbiter_pkg;

  localparam int unsigned PQ_NUM_REQ     = 2;
  localparam int unsigned PQ_PRIM_IDX_W  = 8;
  localparam int unsigned PQ_NODE_IDX_W  = 6;
  localparam int unsigned PQ_MEM_LATENCY = 2;

  typedef enum logic [1:0] {
    REQ_CLOSEST_HIT = 2'd0,
    REQ_SHADOW      = 2'd1,
    REQ_REFLECT     = 2'd2
  } req_id_e;

  typedef logic [PQ_PRIM_IDX_W-1:0] prim_idx_t;
  typedef logic [PQ_NODE_IDX_W-1:0] node_idx_t;

  typedef struct packed {
    prim_idx_t start_idx;
    prim_idx_t end_idx;
    node_idx_t node_idx;
  } prim_query_t;

  typedef enum logic {
    ARB_ROUND_ROBIN = 1'b0,
    ARB_LOCKED      = 1'b1
  } arb_state_e;

  // A requester ID must be at least one bit wide, even for a single requester.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prim_query_arbiter_if.sv
// rtl/prim_query_arbiter_if.sv - requester/memory bus bundle for the primitive query arbiter
//
// Signals:
//   req, req_start, req_end, req_node : per-requester range queries (flattened)
//   gnt, rsp_valid                     : one-hot grant and returned-data strobe
//   mem_ready                          : shared read port accepts a query
//   q_valid, q_start, q_end, q_node    : query issued on the shared port
//   busy                               : any query in flight
//   lock                               : per-requester port lock (PQARB_LOCK_EN only)
// Modports: slave = arbiter side, master = requesters/memory side.
interface prim_query_arbiter_if
  import prim_query_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = PQ_NUM_REQ,
  parameter int unsigned PRIM_IDX_W = PQ_PRIM_IDX_W,
  parameter int unsigned NODE_IDX_W = PQ_NODE_IDX_W
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*PRIM_IDX_W-1:0] req_start;
  logic [NUM_REQ*PRIM_IDX_W-1:0] req_end;
  logic [NUM_REQ*NODE_IDX_W-1:0] req_node;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic                          mem_ready;
  logic                          q_valid;
  logic [PRIM_IDX_W-1:0]         q_start;
  logic [PRIM_IDX_W-1:0]         q_end;
  logic [NODE_IDX_W-1:0]         q_node;
  logic                          busy;
`ifdef PQARB_LOCK_EN
  logic [NUM_REQ-1:0]            lock;

  modport slave (
    input  req, req_start, req_end, req_node, mem_ready, lock,
    output gnt, rsp_valid, q_valid, q_start, q_end, q_node, busy
  );

  modport master (
    output req, req_start, req_end, req_node, mem_ready, lock,
    input  gnt, rsp_valid, q_valid, q_start, q_end, q_node, busy
  );
`else
  modport slave (
    input  req, req_start, req_end, req_node, mem_ready,
    output gnt, rsp_valid, q_valid, q_start, q_end, q_node, busy
  );

  modport master (
    output req, req_start, req_end, req_node, mem_ready,
    input  gnt, rsp_valid, q_valid, q_start, q_end, q_node, busy
  );
`endif

endinterface

// File: rtl/prim_query_tag_pipe.sv
// rtl/prim_query_tag_pipe.sv - fixed-latency {valid,id} tag pipeline steering rsp_valid
//
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   in_valid    : a grant was made this cycle
//   in_id       : ID of the granted requester
//   rsp_valid   : one-hot, registered, DEPTH+1 cycles after in_valid
//   pipe_busy   : any stage holds a valid tag
module prim_query_tag_pipe #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1,
  parameter int unsigned DEPTH   = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  input  logic [ID_W-1:0]    in_id,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic               pipe_busy
);

  logic [DEPTH-1:0] vld_q;
  logic [ID_W-1:0]  id_q [DEPTH];

  // Stage 0 loads alongside q_valid, so the tag sits in stage DEPTH-1 exactly
  // DEPTH-1 cycles after issue; the registered decode below adds the final cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q     <= '0;
      rsp_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        id_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid;
      id_q[0]  <= in_id;
      for (int k = 1; k < DEPTH; k++) begin
        vld_q[k] <= vld_q[k-1];
        id_q[k]  <= id_q[k-1];
      end
      rsp_valid <= '0;
      if (vld_q[DEPTH-1]) begin
        rsp_valid[id_q[DEPTH-1]] <= 1'b1;
      end
    end
  end

  assign pipe_busy = |vld_q;

endmodule

// File: rtl/prim_query_arbiter.sv
// rtl/prim_query_arbiter.sv - round-robin arbiter sharing one primitive/BVH-node read port
//
// Ports:
//   clk    : clock
//   resetn : asynchronous active-low reset
//   bus    : prim_query_arbiter_if.slave (requests, grant, shared query port,
//            response steering, busy)
// Optional: define PQARB_LOCK_EN to add the per-requester lock input and the
//           ARB_ROUND_ROBIN / ARB_LOCKED ownership FSM.
module prim_query_arbiter
  import prim_query_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ     = PQ_NUM_REQ,
  parameter int unsigned PRIM_IDX_W  = PQ_PRIM_IDX_W,
  parameter int unsigned NODE_IDX_W  = PQ_NODE_IDX_W,
  parameter int unsigned MEM_LATENCY = PQ_MEM_LATENCY
) (
  input  logic                 clk,
  input  logic                 resetn,
  prim_query_arbiter_if.slave  bus
);

  localparam int unsigned ID_W = id_width(NUM_REQ);
  typedef logic [ID_W-1:0] id_t;

  id_t                   rr_ptr;
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    gnt_c;
  logic                  gnt_any;
  id_t                   gnt_id;
  logic [ID_W:0]         cand;
  logic                  rr_load;
  id_t                   rr_next;

  logic [PRIM_IDX_W-1:0] sel_start;
  logic [PRIM_IDX_W-1:0] sel_end;
  logic [NODE_IDX_W-1:0] sel_node;

  logic                  q_valid_q;
  logic [PRIM_IDX_W-1:0] q_start_q;
  logic [PRIM_IDX_W-1:0] q_end_q;
  logic [NODE_IDX_W-1:0] q_node_q;
  logic                  pipe_busy;

  function automatic id_t wrap_inc(input id_t v);
    logic [ID_W:0] s;
    s = {1'b0, v} + (ID_W+1)'(1);
    if (s >= (ID_W+1)'(NUM_REQ)) begin
      s = '0;
    end
    return s[ID_W-1:0];
  endfunction

  // Search upward from rr_ptr with wrap; first eligible requester wins.
  // Grant is held low during reset so nothing is consumed while the port is dead.
  always_comb begin
    gnt_c   = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    if (resetn && bus.mem_ready) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
        if (cand >= (ID_W+1)'(NUM_REQ)) begin
          cand = cand - (ID_W+1)'(NUM_REQ);
        end
        if (!gnt_any && eligible[cand[ID_W-1:0]]) begin
          gnt_any = 1'b1;
          gnt_id  = cand[ID_W-1:0];
        end
      end
    end
    if (gnt_any) begin
      gnt_c[gnt_id] = 1'b1;
    end
  end

  always_comb begin
    sel_start = '0;
    sel_end   = '0;
    sel_node  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_c[i]) begin
        sel_start = bus.req_start[i*PRIM_IDX_W +: PRIM_IDX_W];
        sel_end   = bus.req_end[i*PRIM_IDX_W +: PRIM_IDX_W];
        sel_node  = bus.req_node[i*NODE_IDX_W +: NODE_IDX_W];
      end
    end
  end

`ifdef PQARB_LOCK_EN
  arb_state_e state_q;
  arb_state_e state_d;
  id_t        owner_q;
  id_t        owner_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ARB_ROUND_ROBIN;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // The owner leaves the lock either by taking a final grant without lock, or
  // by abandoning the port altogether (req and lock both low).
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ARB_ROUND_ROBIN: begin
        if (gnt_any && bus.lock[gnt_id]) begin
          state_d = ARB_LOCKED;
          owner_d = gnt_id;
        end
      end
      ARB_LOCKED: begin
        if ((gnt_any && !bus.lock[owner_q]) ||
            (!bus.req[owner_q] && !bus.lock[owner_q])) begin
          state_d = ARB_ROUND_ROBIN;
        end
      end
      default: state_d = ARB_ROUND_ROBIN;
    endcase
  end

  always_comb begin
    eligible = '0;
    if (state_q == ARB_LOCKED) begin
      eligible[owner_q] = bus.req[owner_q];
    end else begin
      eligible = bus.req;
    end
  end

  // Entering the lock keeps rr_ptr; it moves past the owner only when the lock ends.
  assign rr_load = (state_q == ARB_LOCKED) ? (state_d == ARB_ROUND_ROBIN)
                                           : (gnt_any && !bus.lock[gnt_id]);
  assign rr_next = wrap_inc((state_q == ARB_LOCKED) ? owner_q : gnt_id);
`else
  assign eligible = bus.req;
  assign rr_load  = gnt_any;
  assign rr_next  = wrap_inc(gnt_id);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr    <= '0;
      q_valid_q <= 1'b0;
      q_start_q <= '0;
      q_end_q   <= '0;
      q_node_q  <= '0;
    end else begin
      if (rr_load) begin
        rr_ptr <= rr_next;
      end
      q_valid_q <= gnt_any;
      if (gnt_any) begin
        q_start_q <= sel_start;
        q_end_q   <= sel_end;
        q_node_q  <= sel_node;
      end
    end
  end

  prim_query_tag_pipe #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .DEPTH   (MEM_LATENCY)
  ) u_tag_pipe (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (gnt_any),
    .in_id     (gnt_id),
    .rsp_valid (bus.rsp_valid),
    .pipe_busy (pipe_busy)
  );

  assign bus.gnt     = gnt_c;
  assign bus.q_valid = q_valid_q;
  assign bus.q_start = q_start_q;
  assign bus.q_end   = q_end_q;
  assign bus.q_node  = q_node_q;
  assign bus.busy    = q_valid_q | pipe_busy;

endmodule

// File: tb/tb_prim_query_arbiter.sv
// tb/tb_prim_query_arbiter.sv - self-checking bench for prim_query_arbiter (2 requesters, latency 2)
module tb_prim_query_arbiter;
  import prim_query_arbiter_pkg::*;

  localparam int L = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  prim_query_arbiter_if #(.NUM_REQ(2), .PRIM_IDX_W(8), .NODE_IDX_W(6)) bus ();

  prim_query_arbiter #(
    .NUM_REQ(2), .PRIM_IDX_W(8), .NODE_IDX_W(6), .MEM_LATENCY(L)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [1:0]  req;
    logic        mr;
    logic [1:0]  exp_gnt;
    prim_query_t q0;
    prim_query_t q1;
  } vec_t;

  typedef struct { int due; prim_query_t q; } q_exp_t;
  typedef struct { int due; int id; } r_exp_t;

  q_exp_t     q_sb[$];
  r_exp_t     r_sb[$];
  vec_t       tbl[$];
  bit         mon_en = 1'b0;
  bit         exp_busy;
  logic [1:0] cur_lock = 2'b00;
  int         checks = 0;
  int         passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic vec_t mk(input logic [1:0] req, input logic mr, input logic [1:0] g, input int n);
    vec_t v;
    v.req = req;
    v.mr = mr;
    v.exp_gnt = g;
    v.q0.start_idx = 8'(n * 4);
    v.q0.end_idx   = 8'(n * 4 + 3);
    v.q0.node_idx  = 6'(n);
    v.q1.start_idx = 8'(100 + n);
    v.q1.end_idx   = 8'(150 + n);
    v.q1.node_idx  = 6'(n + 20);
    return v;
  endfunction

  // Drive one cycle of requests, check the combinational grant, and queue the
  // query and response the bench expects that grant to produce.
  task automatic step(input string name, input vec_t v);
    @(negedge clk);
    bus.req       = v.req;
    bus.mem_ready = v.mr;
    bus.req_start = {v.q1.start_idx, v.q0.start_idx};
    bus.req_end   = {v.q1.end_idx, v.q0.end_idx};
    bus.req_node  = {v.q1.node_idx, v.q0.node_idx};
`ifdef PQARB_LOCK_EN
    bus.lock      = cur_lock;
`endif
    #1;
    chk(name, 32'(bus.gnt), 32'(v.exp_gnt));
    if (v.exp_gnt != 2'b00) begin
      q_sb.push_back('{due: cyc + 1, q: (v.exp_gnt[1] ? v.q1 : v.q0)});
      r_sb.push_back('{due: cyc + 1 + L, id: (v.exp_gnt[1] ? 1 : 0)});
    end
  endtask

  // Monitor: registered outputs compared against the scoreboard every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && resetn) begin
        exp_busy = 1'b0;
        foreach (r_sb[i]) begin
          if (r_sb[i].due > cyc && r_sb[i].due <= cyc + L) exp_busy = 1'b1;
        end
        chk("busy", 32'(bus.busy), 32'(exp_busy));
        if (q_sb.size() > 0 && q_sb[0].due == cyc) begin
          chk("q_valid", 32'(bus.q_valid), 32'd1);
          chk("q_start", 32'(bus.q_start), 32'(q_sb[0].q.start_idx));
          chk("q_end", 32'(bus.q_end), 32'(q_sb[0].q.end_idx));
          chk("q_node", 32'(bus.q_node), 32'(q_sb[0].q.node_idx));
          void'(q_sb.pop_front());
        end else begin
          chk("q_valid_idle", 32'(bus.q_valid), 32'd0);
        end
        if (r_sb.size() > 0 && r_sb[0].due == cyc) begin
          chk("rsp_valid", 32'(bus.rsp_valid), 32'd1 << r_sb[0].id);
          void'(r_sb.pop_front());
        end else begin
          chk("rsp_valid_idle", 32'(bus.rsp_valid), 32'd0);
        end
      end
    end
  end

  initial begin
    bus.req = '0;
    bus.mem_ready = 1'b0;
    bus.req_start = '0;
    bus.req_end = '0;
    bus.req_node = '0;
`ifdef PQARB_LOCK_EN
    bus.lock = '0;
`endif

    // Reset state, with requests pending so the grant gating is exercised.
    repeat (2) @(negedge clk);
    bus.req = 2'b11;
    bus.mem_ready = 1'b1;
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_q_valid", 32'(bus.q_valid), 32'd0);
    chk("rst_q_start", 32'(bus.q_start), 32'd0);
    chk("rst_q_end", 32'(bus.q_end), 32'd0);
    chk("rst_q_node", 32'(bus.q_node), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    bus.req = 2'b00;
    @(negedge clk);
    resetn = 1'b1;
    #2 mon_en = 1'b1;

    // Single requester 1 with the 5/9/3 query, then drain.
    tbl.push_back(mk(2'b10, 1'b1, 2'b10, 0));
    tbl[0].q1.start_idx = 8'd5;
    tbl[0].q1.end_idx   = 8'd9;
    tbl[0].q1.node_idx  = 6'd3;
    for (int i = 1; i <= 3; i++) tbl.push_back(mk(2'b00, 1'b1, 2'b00, i));
    // Both requesting continuously: strict alternation.
    for (int i = 0; i < 3; i++) begin
      tbl.push_back(mk(2'b11, 1'b1, 2'b01, 4 + 2 * i));
      tbl.push_back(mk(2'b11, 1'b1, 2'b10, 5 + 2 * i));
    end
    // mem_ready low for three cycles mid-stream.
    tbl.push_back(mk(2'b11, 1'b1, 2'b01, 10));
    tbl.push_back(mk(2'b11, 1'b1, 2'b10, 11));
    for (int i = 12; i <= 14; i++) tbl.push_back(mk(2'b11, 1'b0, 2'b00, i));
    tbl.push_back(mk(2'b11, 1'b1, 2'b01, 15));
    tbl.push_back(mk(2'b11, 1'b1, 2'b10, 16));
    // Requester 1 pulses once while requester 0 wins, then once while memory stalls.
    tbl.push_back(mk(2'b00, 1'b1, 2'b00, 17));
    tbl.push_back(mk(2'b11, 1'b1, 2'b01, 18));
    tbl.push_back(mk(2'b01, 1'b1, 2'b01, 19));
    tbl.push_back(mk(2'b10, 1'b0, 2'b00, 20));
    for (int i = 21; i <= 24; i++) tbl.push_back(mk(2'b00, 1'b1, 2'b00, i));

    for (int i = 0; i < tbl.size(); i++) step($sformatf("vec%0d_gnt", i), tbl[i]);

    // Reset with two queries in flight (rr_ptr is 1 here).
    step("pre_rst_gnt_a", mk(2'b11, 1'b1, 2'b10, 30));
    step("pre_rst_gnt_b", mk(2'b11, 1'b1, 2'b01, 31));
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    resetn = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_q_valid", 32'(bus.q_valid), 32'd0);
    chk("midrst_gnt", 32'(bus.gnt), 32'd0);
    q_sb.delete();
    r_sb.delete();
    repeat (2) @(negedge clk);
    bus.req = 2'b00;
    resetn = 1'b1;
    #2 mon_en = 1'b1;
    step("post_rst_first_gnt", mk(2'b11, 1'b1, 2'b01, 40));
    step("post_rst_second_gnt", mk(2'b11, 1'b1, 2'b10, 41));
    for (int i = 0; i < 5; i++) step("post_rst_idle", mk(2'b00, 1'b1, 2'b00, 42 + i));

    // Requester 0 holds the port for three grants while requester 1 keeps asking.
`ifdef PQARB_LOCK_EN
    cur_lock = 2'b01;
    step("lock_gnt0", mk(2'b11, 1'b1, 2'b01, 50));
    step("lock_gnt1", mk(2'b11, 1'b1, 2'b01, 51));
    cur_lock = 2'b00;
    step("lock_gnt2", mk(2'b11, 1'b1, 2'b01, 52));
    step("lock_gnt3", mk(2'b11, 1'b1, 2'b10, 53));
`else
    step("alt_gnt0", mk(2'b11, 1'b1, 2'b01, 50));
    step("alt_gnt1", mk(2'b11, 1'b1, 2'b10, 51));
    step("alt_gnt2", mk(2'b11, 1'b1, 2'b01, 52));
    step("alt_gnt3", mk(2'b11, 1'b1, 2'b10, 53));
`endif
    for (int i = 0; i < 5; i++) step("final_idle", mk(2'b00, 1'b1, 2'b00, 54 + i));

    chk("scoreboard_drained", 32'(q_sb.size() + r_sb.size()), 32'd0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
